traffic_light_ctrl: RTL and testbench
=====================================

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter TICK_DIV, 50_000_000, clock cycles per time unit (tick); SHALL be >= 2.
REQ-002 Parameter T_MAIN_MIN, 20, minimum main-green duration in ticks; SHALL be >= 1.
REQ-003 Parameter T_SIDE, 15, side-green duration in ticks; SHALL be >= 1.
REQ-004 Parameter T_YEL, 3, yellow duration in ticks, both approaches; SHALL be >= 1.
REQ-005 Parameter T_ALLRED, 2, all-red clearance duration in ticks; SHALL be >= 1.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 side_req  in  1  side-street or pedestrian request; any width of pulse.
REQ-009 flash_mode  in  1  night mode; level-sensitive.
REQ-010 main_r, main_y, main_g  out  1 each  main-approach lamps.
REQ-011 side_r, side_y, side_g  out  1 each  side-approach lamps.
REQ-012 remain  out  CNT_W  ticks remaining in current phase; CNT_W = $clog2(max(T_MAIN_MIN,T_SIDE,T_YEL,T_ALLRED)+1).
REQ-013 req_pend  out  1  latched side request, not yet served.

Function
REQ-014 States: ALLR_M (all red, next MAIN_G), MAIN_G, MAIN_Y, ALLR_S (all red, next SIDE_G), SIDE_G, SIDE_Y, FLASH.
REQ-015 Lamp decode is combinational from the state register: ALLR_x -> main_r,side_r; MAIN_G -> main_g,side_r; MAIN_Y -> main_y,side_r; SIDE_G -> side_g,main_r; SIDE_Y -> side_y,main_r; FLASH -> main_y=side_y=flash phase, all others 0.
REQ-016 Prescaler counts 0..TICK_DIV-1 and wraps; tick = 1 for one cycle when count == TICK_DIV-1; prescaler clears to 0 on every state change.
REQ-017 Phase counter sec_cnt increments on tick; clears to 0 on every state change; in MAIN_G it saturates at T_MAIN_MIN-1.
REQ-018 Timed state with duration D (ALLR_M/ALLR_S: T_ALLRED, MAIN_Y/SIDE_Y: T_YEL, SIDE_G: T_SIDE) SHALL advance on the edge where tick=1 and sec_cnt == D-1; the state therefore lasts exactly D*TICK_DIV cycles.
REQ-019 Sequence: ALLR_M -> MAIN_G -> MAIN_Y -> ALLR_S -> SIDE_G -> SIDE_Y -> ALLR_M.
REQ-020 MAIN_G SHALL advance to MAIN_Y only on a tick with sec_cnt == T_MAIN_MIN-1 and (req_pend or side_req); otherwise it holds indefinitely, checking again at each subsequent tick.
REQ-021 req_pend sets on any cycle with side_req=1; clears on the edge entering SIDE_G; if set and clear coincide, clear wins.
REQ-022 flash_mode=1 SHALL force FLASH on the next edge from any state, with no intermediate yellow.
REQ-023 In FLASH, the flash phase starts at 1 on entry and toggles on each tick; req_pend holds its value.
REQ-024 flash_mode=0 while in FLASH SHALL move to ALLR_M on the next edge.
REQ-025 remain = D-1-sec_cnt in timed states; T_MAIN_MIN-1-sec_cnt in MAIN_G (it reaches 0 and holds there); 0 in FLASH.

Reset
REQ-026 rst=1 at a rising edge SHALL set: state ALLR_M, prescaler 0, sec_cnt 0, req_pend 0, flash phase 0.
REQ-027 Outputs during and directly after reset: main_r=side_r=1; all other lamps 0; remain = T_ALLRED-1.
REQ-028 rst SHALL take priority over flash_mode and side_req, including when asserted mid-phase.

Structure
REQ-029 Package tl_pkg SHALL hold the state enum tl_state_t and the default timing constants.
REQ-030 The prescaler SHALL be a sub-module tick_gen, with parameter DIV and ports clk, rst, clr, tick.
REQ-031 Exactly one state register and one next-state always_comb block; no latches or combinational loops.

Verification (TICK_DIV=4, T_MAIN_MIN=3, T_SIDE=2, T_YEL=1, T_ALLRED=2)
REQ-032 Release reset, no requests -> ALLR_M for 8 cycles, then MAIN_G, which holds with remain=0 indefinitely.
REQ-033 One-cycle side_req at cycle 2 of MAIN_G -> req_pend=1; MAIN_G lasts 12 cycles, then MAIN_Y 4, ALLR_S 8, SIDE_G 8 (req_pend clears on entry), SIDE_Y 4, ALLR_M 8.
REQ-034 side_req held high through the SIDE_G entry edge -> req_pend=0 after that edge (clear wins), then 1 on the following cycle.
REQ-035 flash_mode asserted mid-SIDE_G -> FLASH on the next edge; main_y=side_y toggle every 4 cycles, starting at 1; deasserted -> ALLR_M on the next edge.
REQ-036 rst pulsed during MAIN_Y -> ALLR_M with remain=1 on the following cycle; req_pend=0.

Source files
------------

// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tl_pkg
//  Description : Shared state encoding, default timing constants and the
//                phase-counter width helper for the traffic light controller.
//  Revision    : 1.0  initial release
// ============================================================================
package tl_pkg;

   typedef enum logic [2:0] {
      ALLR_M = 3'd0,   // all red, MAIN_G follows
      MAIN_G = 3'd1,
      MAIN_Y = 3'd2,
      ALLR_S = 3'd3,   // all red, SIDE_G follows
      SIDE_G = 3'd4,
      SIDE_Y = 3'd5,
      FLASH  = 3'd6
   } tl_state_t;

   localparam int DEF_TICK_DIV   = 50_000_000;
   localparam int DEF_T_MAIN_MIN = 20;
   localparam int DEF_T_SIDE     = 15;
   localparam int DEF_T_YEL      = 3;
   localparam int DEF_T_ALLRED   = 2;

   // Bits needed to hold the longest phase duration
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Free-running prescaler producing a one-cycle tick every DIV
//                clocks; clr restarts the count so a new phase starts aligned.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_gen
   import tl_pkg::*;
#(
   parameter int DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int             CW   = $clog2(DIV);
   localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   // Count 0..DIV-1 and wrap; reset and clr both restart at zero
   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (count == LAST)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   assign tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_ctrl
//  Description : Main/side intersection controller with demand-actuated side
//                phase, yellow and all-red clearance, and night flash mode.
//  Revision    : 1.0  initial release
// ============================================================================
module traffic_light_ctrl
   import tl_pkg::*;
#(
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int T_MAIN_MIN = DEF_T_MAIN_MIN,
   parameter int T_SIDE     = DEF_T_SIDE,
   parameter int T_YEL      = DEF_T_YEL,
   parameter int T_ALLRED   = DEF_T_ALLRED
) (
   input  logic clk,
   input  logic rst,
   input  logic side_req,
   input  logic flash_mode,
   output logic main_r,
   output logic main_y,
   output logic main_g,
   output logic side_r,
   output logic side_y,
   output logic side_g,
   output logic [cnt_width(T_MAIN_MIN, T_SIDE, T_YEL, T_ALLRED)-1:0] remain,
   output logic req_pend
);

   localparam int CNT_W = cnt_width(T_MAIN_MIN, T_SIDE, T_YEL, T_ALLRED);

   // Last sec_cnt value of each phase (duration - 1)
   localparam logic [CNT_W-1:0] MAIN_LAST = CNT_W'(T_MAIN_MIN - 1);
   localparam logic [CNT_W-1:0] SIDE_LAST = CNT_W'(T_SIDE - 1);
   localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YEL - 1);
   localparam logic [CNT_W-1:0] ALLR_LAST = CNT_W'(T_ALLRED - 1);

   tl_state_t        state;
   tl_state_t        state_nx;
   logic             tick;
   logic             state_chg;
   logic             phase_done;
   logic             flash_ph;
   logic [CNT_W-1:0] sec_cnt;
   logic [CNT_W-1:0] phase_last;

   // Prescaler restarts on every state change so each phase lasts D*TICK_DIV
   tick_gen #(
      .DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_chg),
      .tick (tick)
   );

   // Final sec_cnt value for the current phase
   always_comb begin
      phase_last = '0;
      case (state)
         ALLR_M, ALLR_S: phase_last = ALLR_LAST;
         MAIN_G:         phase_last = MAIN_LAST;
         MAIN_Y, SIDE_Y: phase_last = YEL_LAST;
         SIDE_G:         phase_last = SIDE_LAST;
         default:        phase_last = '0;
      endcase
   end

   assign phase_done = tick && (sec_cnt == phase_last);

   // Next-state logic; flash_mode overrides everything except reset
   always_comb begin
      state_nx = state;
      if (flash_mode) begin
         state_nx = FLASH;
      end else begin
         case (state)
            ALLR_M:  if (phase_done) state_nx = MAIN_G;
            MAIN_G:  if (phase_done && (req_pend || side_req)) state_nx = MAIN_Y;
            MAIN_Y:  if (phase_done) state_nx = ALLR_S;
            ALLR_S:  if (phase_done) state_nx = SIDE_G;
            SIDE_G:  if (phase_done) state_nx = SIDE_Y;
            SIDE_Y:  if (phase_done) state_nx = ALLR_M;
            FLASH:   state_nx = ALLR_M;
            default: state_nx = ALLR_M;
         endcase
      end
   end

   assign state_chg = (state_nx != state);

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= ALLR_M;
      else
         state <= state_nx;
   end

   // Phase counter; MAIN_G saturates so it can hold for demand indefinitely
   always_ff @(posedge clk) begin
      if (rst || state_chg)
         sec_cnt <= '0;
      else if (tick && !(state == MAIN_G && sec_cnt == MAIN_LAST))
         sec_cnt <= sec_cnt + 1'b1;
   end

   // Side request latch; the clear on SIDE_G entry beats a coincident request
   always_ff @(posedge clk) begin
      if (rst)
         req_pend <= 1'b0;
      else if (state_chg && state_nx == SIDE_G)
         req_pend <= 1'b0;
      else if (side_req && state != FLASH)
         req_pend <= 1'b1;
   end

   // Flash phase starts lit on entry and toggles every tick while flashing
   always_ff @(posedge clk) begin
      if (rst)
         flash_ph <= 1'b0;
      else if (state_chg && state_nx == FLASH)
         flash_ph <= 1'b1;
      else if (state == FLASH && tick)
         flash_ph <= ~flash_ph;
   end

   // Lamp decode from the state register
   always_comb begin
      main_r = 1'b0;
      main_y = 1'b0;
      main_g = 1'b0;
      side_r = 1'b0;
      side_y = 1'b0;
      side_g = 1'b0;
      case (state)
         ALLR_M, ALLR_S: begin main_r = 1'b1; side_r = 1'b1; end
         MAIN_G:         begin main_g = 1'b1; side_r = 1'b1; end
         MAIN_Y:         begin main_y = 1'b1; side_r = 1'b1; end
         SIDE_G:         begin side_g = 1'b1; main_r = 1'b1; end
         SIDE_Y:         begin side_y = 1'b1; main_r = 1'b1; end
         FLASH:          begin main_y = flash_ph; side_y = flash_ph; end
         default:        begin main_r = 1'b1; side_r = 1'b1; end
      endcase
   end

   // sec_cnt never exceeds phase_last, so the difference cannot underflow
   assign remain = (state == FLASH) ? '0 : (phase_last - sec_cnt);

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_ctrl
//  Description : Directed scoreboard bench for traffic_light_ctrl with
//                TICK_DIV=4, T_MAIN_MIN=3, T_SIDE=2, T_YEL=1, T_ALLRED=2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_traffic_light_ctrl;

   localparam int TD = 4;

   // lamp vector order: {main_r, main_y, main_g, side_r, side_y, side_g}
   localparam logic [5:0] L_ALLR = 6'b100100;
   localparam logic [5:0] L_MG   = 6'b001100;
   localparam logic [5:0] L_MY   = 6'b010100;
   localparam logic [5:0] L_SG   = 6'b100001;
   localparam logic [5:0] L_SY   = 6'b100010;
   localparam logic [5:0] L_FL   = 6'b010010;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       side_req = 1'b0;
   logic       flash_mode = 1'b0;
   logic       main_r, main_y, main_g, side_r, side_y, side_g;
   logic [1:0] remain;
   logic       req_pend;
   logic [5:0] lamps_now;

   typedef struct {
      bit [63:0]  nm;
      int         k;
      logic [5:0] lamps;
      logic [1:0] rem;
      logic       rp;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   traffic_light_ctrl #(
      .TICK_DIV   (4),
      .T_MAIN_MIN (3),
      .T_SIDE     (2),
      .T_YEL      (1),
      .T_ALLRED   (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .side_req   (side_req),
      .flash_mode (flash_mode),
      .main_r     (main_r),
      .main_y     (main_y),
      .main_g     (main_g),
      .side_r     (side_r),
      .side_y     (side_y),
      .side_g     (side_g),
      .remain     (remain),
      .req_pend   (req_pend)
   );

   assign lamps_now = {main_r, main_y, main_g, side_r, side_y, side_g};

   // Monitor: compare the outputs of this cycle against what stimulus queued
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_vec++;
         if (lamps_now !== e.lamps || remain !== e.rem || req_pend !== e.rp) begin
            n_err++;
            $display("FAIL %0s k=%0d: got lamps=%b remain=%0d req_pend=%b, expected lamps=%b remain=%0d req_pend=%b",
                     e.nm, e.k, lamps_now, remain, req_pend, e.lamps, e.rem, e.rp);
         end
      end
   end

   task automatic push(input bit [63:0] nm, input int k, input logic [5:0] l,
                       input int rem, input logic rp);
      exp_t e;
      e.nm = nm; e.k = k; e.lamps = l; e.rem = 2'(rem); e.rp = rp;
      exp_q.push_back(e);
   endtask

   // Reset edge with optional competing inputs; outputs must show ALLR_M
   task automatic do_reset(input bit fl, input bit sr);
      rst = 1'b1; flash_mode = fl; side_req = sr;
      @(posedge clk); #1;
      push("reset", 0, L_ALLR, 1, 1'b0);
      rst = 1'b0; flash_mode = 1'b0; side_req = 1'b0;
   endtask

   // One phase, cycle by cycle: k=0 is the cycle right after the entry edge.
   // d = duration in ticks; remain counts down per tick and bottoms out at 0.
   task automatic phase(input bit [63:0] nm, input logic [5:0] l, input bit fl,
                        input int k0, input int n, input int d,
                        input bit rp0, input bit rp1, input int k_sw,
                        input int set_k, input int clr_k);
      for (int k = k0; k < n; k++) begin
         int         rem;
         logic [5:0] le;
         @(posedge clk); #1;
         rem = d - 1 - k / TD;
         if (rem < 0) rem = 0;
         le = l;
         if (fl) begin
            rem = 0;
            le  = ((k / TD) % 2 == 0) ? L_FL : 6'b000000;
         end
         push(nm, k, le, rem, (k >= k_sw) ? rp1 : rp0);
         if (k == set_k) side_req = 1'b1;
         if (k == clr_k) side_req = 1'b0;
      end
   endtask

   initial begin
      @(posedge clk);
      // No demand: ALLR_M for 8 cycles, then MAIN_G holds with remain 0
      do_reset(1'b0, 1'b0);
      phase("ALLR_M", L_ALLR, 0, 1, 8, 2, 0, 0, 0, -1, -1);
      phase("MG_hold", L_MG, 0, 0, 24, 3, 0, 0, 0, -1, -1);

      // One-cycle request in MAIN_G: full cycle back to ALLR_M
      do_reset(1'b0, 1'b0);
      phase("ALLR_M", L_ALLR, 0, 1, 8, 2, 0, 0, 0, -1, -1);
      phase("MG_req", L_MG, 0, 0, 12, 3, 0, 1, 3, 2, 3);
      phase("MAIN_Y", L_MY, 0, 0, 4, 1, 1, 1, 0, -1, -1);
      phase("ALLR_S", L_ALLR, 0, 0, 8, 2, 1, 1, 0, -1, -1);
      phase("SIDE_G", L_SG, 0, 0, 8, 2, 0, 0, 0, -1, -1);
      phase("SIDE_Y", L_SY, 0, 0, 4, 1, 0, 0, 0, -1, -1);
      // side_req rises at the end of ALLR_M and stays high into SIDE_G
      phase("ALLR_M2", L_ALLR, 0, 0, 8, 2, 0, 0, 0, 7, -1);
      phase("MG_held", L_MG, 0, 0, 12, 3, 1, 1, 0, -1, -1);
      phase("MAIN_Y2", L_MY, 0, 0, 4, 1, 1, 1, 0, -1, -1);
      phase("ALLR_S2", L_ALLR, 0, 0, 8, 2, 1, 1, 0, -1, -1);
      // Entry edge clears (clear wins), next edge re-latches the held request
      phase("SG_clrwin", L_SG, 0, 0, 8, 2, 0, 1, 1, -1, 1);
      phase("SIDE_Y3", L_SY, 0, 0, 4, 1, 1, 1, 0, -1, -1);
      phase("ALLR_M3", L_ALLR, 0, 0, 8, 2, 1, 1, 0, -1, -1);
      phase("MG_pend", L_MG, 0, 0, 12, 3, 1, 1, 0, -1, -1);
      phase("MAIN_Y4", L_MY, 0, 0, 4, 1, 1, 1, 0, -1, -1);
      phase("ALLR_S4", L_ALLR, 0, 0, 8, 2, 1, 1, 0, -1, -1);

      // Flash asserted mid-SIDE_G
      phase("SG_part", L_SG, 0, 0, 3, 2, 0, 0, 0, -1, -1);
      flash_mode = 1'b1;
      phase("FLASH", L_FL, 1, 0, 12, 1, 0, 0, 0, -1, -1);
      flash_mode = 1'b0;
      phase("ALLR_Mf", L_ALLR, 0, 0, 8, 2, 0, 0, 0, 7, -1);
      phase("MG_f", L_MG, 0, 0, 12, 3, 1, 1, 0, -1, 0);

      // Reset mid-MAIN_Y, competing with flash_mode and side_req
      phase("MY_part", L_MY, 0, 0, 2, 1, 1, 1, 0, -1, -1);
      do_reset(1'b1, 1'b1);
      phase("ALLR_Mr", L_ALLR, 0, 1, 8, 2, 0, 0, 0, -1, -1);
      phase("MG_r", L_MG, 0, 0, 8, 3, 0, 0, 0, -1, -1);

      @(negedge clk); #1;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
